// File: rtl/branch_resolution_queue_pkg.sv
// Shared types and helpers for the branch resolution queue.
//   bq_entry_t  : one in-flight fetch prediction (pc, pred_taken, pred_target)
//   bq_state_e  : queue control state (RUN / RECOVER)
//   bht_index() : BHT index of a pc (word-aligned low bits)
package bp_pkg;

  localparam int BQ_PC_W     = 64;
  localparam int BQ_LOWER    = 5;
  localparam int INSTR_BYTES = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bq_state_e;

  typedef struct packed {
    logic [BQ_PC_W-1:0] pc;
    logic               pred_taken;
    logic [BQ_PC_W-1:0] pred_target;
  } bq_entry_t;

  // Instructions are 4-byte aligned, so the index skips pc[1:0].
  function automatic logic [BQ_LOWER-1:0] bht_index(input logic [BQ_PC_W-1:0] pc);
    return pc[BQ_LOWER+1:2];
  endfunction

endpackage

// File: rtl/branch_resolution_queue_if.sv
// Fetch/EX/BHT-facing bundle of the branch resolution queue.
//   push_*  : fetch issues a predicted instruction (valid/ready)
//   res_*   : oldest instruction resolves in EX
//   bht_*   : registered update strobe toward the 2-bit-counter BHT
//   mispredict / redirect_pc : registered redirect toward fetch
// master = fetch/EX/BHT side, slave = the queue.
interface branch_resolution_queue_if #(
  parameter int PC_W  = 64,
  parameter int LOWER = 5
);
  logic             push_valid;
  logic             push_ready;
  logic [PC_W-1:0]  push_pc;
  logic             push_pred_taken;
  logic [PC_W-1:0]  push_pred_target;

  logic             res_valid;
  logic             res_is_branch;
  logic             res_is_jump;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;

  logic             bht_en;
  logic [LOWER-1:0] bht_write_addr;
  logic             bht_was_taken;
  logic             bht_jumped;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output res_valid, res_is_branch, res_is_jump, res_taken, res_target,
    input  push_ready,
    input  bht_en, bht_write_addr, bht_was_taken, bht_jumped,
    input  mispredict, redirect_pc
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  res_valid, res_is_branch, res_is_jump, res_taken, res_target,
    output push_ready,
    output bht_en, bht_write_addr, bht_was_taken, bht_jumped,
    output mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_resolution_queue_fifo.sv
// bq_fifo: generic DEPTH-entry circular buffer.
//   push_i/wdata_i : write at wr pointer
//   pop_i          : advance rd pointer (head visible on rdata_o)
//   flush_i        : clear pointers and count; wins over push/pop
//   count_o        : occupancy, 0..DEPTH
// Caller guarantees no push when full and no pop when empty.
module bq_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_i,
  input  T                         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output T                         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-2 depth: pointer overflow is the modulo wrap.
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolution_queue.sv
// branch_resolution_queue: in-order queue of fetch predictions, one entry per
// fetched instruction, popped when that instruction resolves in EX.
//   clk, arst_n    : clock, async active-low reset
//   bus (slave)    : push from fetch, resolve from EX, BHT update + redirect
//   underflow_err  : sticky, resolve seen while the queue was empty
//   mispredict_cnt : saturating count of mispredicts
// A mispredict flushes every younger entry and spends one RECOVER cycle in
// which pushes are refused and resolves are ignored.
module branch_resolution_queue
  import bp_pkg::*;
#(
  parameter int LOWER = BQ_LOWER,
  parameter int DEPTH = 4,
  parameter int PC_W  = BQ_PC_W
) (
  input  logic                        clk,
  input  logic                        arst_n,
  branch_resolution_queue_if.slave    bus,
  output logic                        underflow_err,
  output logic [15:0]                 mispredict_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  bq_state_e       state_q, state_d;
  bq_entry_t       head, wentry;
  logic [CW-1:0]   count;
  logic            run, full, do_res, act_taken, mis;
  logic            fifo_push, fifo_pop;
  logic [PC_W-1:0] act_next;

  logic             bht_en_q, bht_en_d;
  logic [LOWER-1:0] bht_addr_q, bht_addr_d;
  logic             bht_was_taken_q, bht_was_taken_d;
  logic             bht_jumped_q, bht_jumped_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             underflow_q, underflow_d;
  logic [15:0]      mcnt_q, mcnt_d;

  // Only registered state feeds push_ready; no res_* path.
  assign run            = (state_q == RUN);
  assign full           = (count == CW'(DEPTH));
  assign bus.push_ready = !full && run;

  assign do_res    = bus.res_valid && (count != '0) && run;
  assign act_taken = bus.res_is_jump | (bus.res_is_branch & bus.res_taken);
  assign act_next  = act_taken ? bus.res_target : head.pc + PC_W'(INSTR_BYTES);

  // A non-control instruction predicted taken (BHT alias) lands here too:
  // act_taken=0 against pred_taken=1.
  assign mis = do_res &&
               ((head.pred_taken != act_taken) ||
                (act_taken && (head.pred_target != bus.res_target)));

  // A push in the mispredict cycle belongs to the wrong path; drop it.
  assign fifo_push = bus.push_valid && bus.push_ready && !mis;
  assign fifo_pop  = do_res && !mis;

  always_comb begin
    wentry             = '0;
    wentry.pc          = bus.push_pc;
    wentry.pred_taken  = bus.push_pred_taken;
    wentry.pred_target = bus.push_pred_target;
  end

  bq_fifo #(
    .DEPTH (DEPTH),
    .T     (bq_entry_t)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push_i  (fifo_push),
    .wdata_i (wentry),
    .pop_i   (fifo_pop),
    .flush_i (mis),
    .rdata_o (head),
    .count_o (count)
  );

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mis) state_d = RECOVER;
      RECOVER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= RUN;
    else         state_q <= state_d;
  end

  // Output registers and counters
  always_comb begin
    bht_en_d        = 1'b0;
    bht_addr_d      = bht_addr_q;
    bht_was_taken_d = bht_was_taken_q;
    bht_jumped_d    = bht_jumped_q;
    mispredict_d    = mis;
    redirect_pc_d   = redirect_pc_q;
    underflow_d     = underflow_q;
    mcnt_d          = mcnt_q;

    if (do_res && (bus.res_is_branch || bus.res_is_jump)) begin
      bht_en_d        = 1'b1;
      bht_addr_d      = bht_index(head.pc);
      bht_was_taken_d = bus.res_taken;
      bht_jumped_d    = bus.res_is_jump;
    end

    if (mis) begin
      redirect_pc_d = act_next;
      if (mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
    end

    if (bus.res_valid && run && (count == '0)) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bht_en_q        <= 1'b0;
      bht_addr_q      <= '0;
      bht_was_taken_q <= 1'b0;
      bht_jumped_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
      underflow_q     <= 1'b0;
      mcnt_q          <= '0;
    end else begin
      bht_en_q        <= bht_en_d;
      bht_addr_q      <= bht_addr_d;
      bht_was_taken_q <= bht_was_taken_d;
      bht_jumped_q    <= bht_jumped_d;
      mispredict_q    <= mispredict_d;
      redirect_pc_q   <= redirect_pc_d;
      underflow_q     <= underflow_d;
      mcnt_q          <= mcnt_d;
    end
  end

  assign bus.bht_en         = bht_en_q;
  assign bus.bht_write_addr = bht_addr_q;
  assign bus.bht_was_taken  = bht_was_taken_q;
  assign bus.bht_jumped     = bht_jumped_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign underflow_err      = underflow_q;
  assign mispredict_cnt     = mcnt_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
module tb_branch_resolution_queue;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        underflow_err;
  logic [15:0] mispredict_cnt;

  branch_resolution_queue_if #(.PC_W(64), .LOWER(5)) bus ();

  branch_resolution_queue #(.LOWER(5), .DEPTH(4), .PC_W(64)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .bus            (bus),
    .underflow_err  (underflow_err),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic        pt;
    logic [63:0] ptgt;
    logic        br;
    logic        jp;
    logic        tk;
    logic [63:0] tgt;
    logic        e_en;
    logic [4:0]  e_addr;
    logic        e_wt;
    logic        e_j;
    logic        e_mis;
    logic [63:0] e_redir;
  } vec_t;

  vec_t        vecs[8];
  vec_t        sb[$];
  logic [63:0] pcq[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.push_valid       = 1'b0;
    bus.push_pc          = '0;
    bus.push_pred_taken  = 1'b0;
    bus.push_pred_target = '0;
    bus.res_valid        = 1'b0;
    bus.res_is_branch    = 1'b0;
    bus.res_is_jump      = 1'b0;
    bus.res_taken        = 1'b0;
    bus.res_target       = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected update and compare against the registered outputs.
  task automatic check_out(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_en"},    {63'd0, bus.bht_en},     {63'd0, e.e_en});
    chk({tag, "_mis"},   {63'd0, bus.mispredict}, {63'd0, e.e_mis});
    chk({tag, "_redir"}, bus.redirect_pc,         e.e_redir);
    if (e.e_en) begin
      chk({tag, "_addr"}, {59'd0, bus.bht_write_addr}, {59'd0, e.e_addr});
      chk({tag, "_wt"},   {63'd0, bus.bht_was_taken},  {63'd0, e.e_wt});
      chk({tag, "_j"},    {63'd0, bus.bht_jumped},     {63'd0, e.e_j});
    end
  endtask

  // One wrap-sequence cycle: optional push of pc=k*4, optional correct
  // not-taken branch resolve whose expected index comes from the pc model.
  task automatic wstep(input bit p, input int k, input bit r, input string tag);
    vec_t        e;
    logic [63:0] hpc;
    @(negedge clk);
    drive_idle();
    if (r) begin
      hpc = pcq.pop_front();
      e = '{pc: hpc, pt: 1'b0, ptgt: 64'd0, br: 1'b1, jp: 1'b0, tk: 1'b0, tgt: 64'd0,
            e_en: 1'b1, e_addr: hpc[6:2], e_wt: 1'b0, e_j: 1'b0, e_mis: 1'b0,
            e_redir: 64'h1000};
      sb.push_back(e);
      bus.res_valid     = 1'b1;
      bus.res_is_branch = 1'b1;
    end
    if (p) begin
      bus.push_valid = 1'b1;
      bus.push_pc    = 64'(k) << 2;
      pcq.push_back(64'(k) << 2);
    end
    cyc();
    if (r) check_out(tag);
  endtask

  initial begin
    //            pc       pt  ptgt     br  jp  tk  tgt       en addr   wt  j   mis redir
    vecs[0] = '{64'h100, 0, 64'h0,   1, 0, 0, 64'h0,    1, 5'h00, 0, 0, 0, 64'h0};
    vecs[1] = '{64'h104, 0, 64'h0,   1, 0, 1, 64'h200,  1, 5'h01, 1, 0, 1, 64'h200};
    vecs[2] = '{64'h40,  1, 64'h80,  0, 1, 1, 64'h90,   1, 5'h10, 1, 1, 1, 64'h90};
    vecs[3] = '{64'h10,  1, 64'h50,  0, 0, 0, 64'h0,    0, 5'h00, 0, 0, 1, 64'h14};
    vecs[4] = '{64'h200, 1, 64'h300, 1, 0, 1, 64'h300,  1, 5'h00, 1, 0, 0, 64'h14};
    vecs[5] = '{64'h7C,  1, 64'h40,  1, 0, 0, 64'h0,    1, 5'h1F, 0, 0, 1, 64'h80};
    vecs[6] = '{64'h84,  0, 64'h0,   0, 1, 1, 64'h1000, 1, 5'h01, 1, 1, 1, 64'h1000};
    vecs[7] = '{64'h300, 0, 64'h0,   1, 0, 0, 64'h0,    1, 5'h00, 0, 0, 0, 64'h1000};

    drive_idle();
    repeat (3) @(negedge clk);
    chk("rst_bht_en",   {63'd0, bus.bht_en},     64'd0);
    chk("rst_mis",      {63'd0, bus.mispredict}, 64'd0);
    chk("rst_redirect", bus.redirect_pc,         64'd0);
    chk("rst_underflow",{63'd0, underflow_err},  64'd0);
    chk("rst_mcnt",     {48'd0, mispredict_cnt}, 64'd0);
    arst_n = 1'b1;
    cyc();
    chk("rst_push_ready", {63'd0, bus.push_ready}, 64'd1);

    // Table-driven single-entry transactions
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle();
      bus.push_valid       = 1'b1;
      bus.push_pc          = vecs[i].pc;
      bus.push_pred_taken  = vecs[i].pt;
      bus.push_pred_target = vecs[i].ptgt;
      cyc();
      @(negedge clk);
      drive_idle();
      bus.res_valid     = 1'b1;
      bus.res_is_branch = vecs[i].br;
      bus.res_is_jump   = vecs[i].jp;
      bus.res_taken     = vecs[i].tk;
      bus.res_target    = vecs[i].tgt;
      sb.push_back(vecs[i]);
      cyc();
      check_out($sformatf("v%0d", i));
      chk($sformatf("v%0d_ready", i), {63'd0, bus.push_ready}, {63'd0, !vecs[i].e_mis});
      @(negedge clk);
      drive_idle();
      cyc();
      chk($sformatf("v%0d_pulse", i), {63'd0, bus.mispredict | bus.bht_en}, 64'd0);
      chk($sformatf("v%0d_ready2", i), {63'd0, bus.push_ready}, 64'd1);
    end
    chk("mcnt_after_vecs", {48'd0, mispredict_cnt}, 64'd5);

    // Full / pointer wrap with concurrent push + correct resolve
    for (int k = 1; k <= 4; k++) wstep(1'b1, k, 1'b0, "fill");
    chk("full_ready", {63'd0, bus.push_ready}, 64'd0);
    wstep(1'b0, 0, 1'b1, "w_pop");
    chk("w_ready_3", {63'd0, bus.push_ready}, 64'd1);
    for (int k = 5; k <= 10; k++) begin
      wstep(1'b1, k, 1'b1, $sformatf("w%0d", k));
      chk($sformatf("w%0d_ready", k), {63'd0, bus.push_ready}, 64'd1);
    end
    wstep(1'b1, 11, 1'b0, "w_refill");
    chk("w_full_again", {63'd0, bus.push_ready}, 64'd0);
    for (int k = 0; k < 4; k++) wstep(1'b0, 0, 1'b1, $sformatf("drain%0d", k));
    chk("w_empty_ready", {63'd0, bus.push_ready}, 64'd1);

    // Flush: two entries, mispredict on the oldest while a push is offered
    @(negedge clk); drive_idle();
    bus.push_valid = 1'b1; bus.push_pc = 64'h104; cyc();
    @(negedge clk); drive_idle();
    bus.push_valid = 1'b1; bus.push_pc = 64'h108; cyc();
    @(negedge clk); drive_idle();
    bus.push_valid = 1'b1; bus.push_pc = 64'h10C;
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1; bus.res_taken = 1'b1;
    bus.res_target = 64'h200;
    sb.push_back('{64'h104, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 64'h200,
                   1'b1, 5'h01, 1'b1, 1'b0, 1'b1, 64'h200});
    cyc();
    check_out("flush");
    chk("flush_recover_ready", {63'd0, bus.push_ready}, 64'd0);
    chk("flush_mcnt", {48'd0, mispredict_cnt}, 64'd6);
    // Resolve offered during RECOVER is ignored (no underflow, no update)
    @(negedge clk); drive_idle();
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1;
    cyc();
    chk("recover_ignore_uf", {63'd0, underflow_err}, 64'd0);
    chk("recover_ignore_en", {63'd0, bus.bht_en}, 64'd0);
    // Queue must now be empty: a resolve underflows
    @(negedge clk); drive_idle();
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1;
    cyc();
    chk("underflow_set", {63'd0, underflow_err}, 64'd1);
    chk("underflow_no_en", {63'd0, bus.bht_en}, 64'd0);
    chk("underflow_no_mis", {63'd0, bus.mispredict}, 64'd0);
    @(negedge clk); drive_idle();
    cyc(); cyc();
    chk("underflow_sticky", {63'd0, underflow_err}, 64'd1);

    // Reset mid-stream, right after a mispredict pulse is registered
    @(negedge clk); drive_idle();
    bus.push_valid = 1'b1; bus.push_pc = 64'h500;
    bus.push_pred_taken = 1'b1; bus.push_pred_target = 64'h600;
    cyc();
    @(negedge clk); drive_idle();
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1; bus.res_taken = 1'b0;
    cyc();
    chk("pre_rst_mis", {63'd0, bus.mispredict}, 64'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("mid_rst_mis",   {63'd0, bus.mispredict}, 64'd0);
    chk("mid_rst_en",    {63'd0, bus.bht_en},     64'd0);
    chk("mid_rst_redir", bus.redirect_pc,         64'd0);
    chk("mid_rst_uf",    {63'd0, underflow_err},  64'd0);
    chk("mid_rst_mcnt",  {48'd0, mispredict_cnt}, 64'd0);
    @(negedge clk); drive_idle();
    arst_n = 1'b1;
    cyc();
    chk("post_rst_ready", {63'd0, bus.push_ready}, 64'd1);
    @(negedge clk); drive_idle();
    bus.res_valid = 1'b1; bus.res_is_branch = 1'b1;
    cyc();
    chk("post_rst_empty_uf", {63'd0, underflow_err}, 64'd1);
    chk("post_rst_no_en", {63'd0, bus.bht_en}, 64'd0);
    @(negedge clk); drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
